// File: rtl/serial_frame_gen.sv
// Serialises a frame MSB-first: N_SYNC COM symbols, n_words handshaked data
// symbols (COM filler on underrun, word retried), then N_TAIL COM symbols.
module serial_frame_gen #(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] COM    = WIDTH'(8'hBC),
  parameter int               N_SYNC = 4,
  parameter int               N_TAIL = 2,
  parameter int               CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_words,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             out_tx,
  output logic             out_active,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam int               BW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0]    BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(N_SYNC - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(N_TAIL - 1);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, TAIL} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [BW-1:0]    bit_cnt, bit_cnt_next;
  logic [CNT_W-1:0] sym_cnt, sym_cnt_next;
  logic [CNT_W-1:0] words_left, words_left_next;
  logic             underrun_next;
  logic             done_next;
  logic             boundary;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      sym_cnt    <= '0;
      words_left <= '0;
      underrun   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      shreg      <= shreg_next;
      bit_cnt    <= bit_cnt_next;
      sym_cnt    <= sym_cnt_next;
      words_left <= words_left_next;
      underrun   <= underrun_next;
      done       <= done_next;
    end
  end

  assign boundary   = (bit_cnt == BIT_LAST);
  assign busy       = (state != IDLE);
  assign out_active = busy;
  assign out_tx     = busy & shreg[WIDTH-1];

  always_comb begin
    state_next      = state;
    shreg_next      = {shreg[WIDTH-2:0], 1'b0};
    bit_cnt_next    = boundary ? '0 : bit_cnt + 1'b1;
    sym_cnt_next    = sym_cnt;
    words_left_next = words_left;
    underrun_next   = underrun;
    done_next       = 1'b0;
    data_ready      = 1'b0;

    unique case (state)
      IDLE: begin
        shreg_next   = '0;
        bit_cnt_next = '0;
        if (start) begin
          state_next      = SYNC;
          shreg_next      = COM;
          sym_cnt_next    = '0;
          words_left_next = n_words;
          underrun_next   = 1'b0;
        end
      end
      SYNC: begin
        if (boundary) begin
          shreg_next = COM;
          if (sym_cnt == SYNC_LAST) begin
            sym_cnt_next = '0;
            if (words_left != '0) begin
              state_next = DATA;
              data_ready = 1'b1;
            end else begin
              state_next = TAIL;
            end
          end else begin
            sym_cnt_next = sym_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        // A filler symbol keeps us in DATA with words_left untouched, so the
        // same word is requested again at the next boundary.
        if (boundary) begin
          shreg_next = COM;
          if (words_left != '0) begin
            data_ready = 1'b1;
          end else begin
            state_next   = TAIL;
            sym_cnt_next = '0;
          end
        end
      end
      TAIL: begin
        if (boundary) begin
          shreg_next = COM;
          if (sym_cnt == TAIL_LAST) begin
            state_next   = IDLE;
            shreg_next   = '0;
            sym_cnt_next = '0;
            done_next    = 1'b1;
          end else begin
            sym_cnt_next = sym_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (data_ready) begin
      if (data_valid) begin
        shreg_next      = data_in;
        words_left_next = words_left - 1'b1;
      end else begin
        underrun_next = 1'b1;
      end
    end
  end

endmodule
